control_cmd_writepixelrun: RTL and testbench

//  - Command-payload parser for a run of consecutive pixels written to the framebuffer.
//  - Sits behind the control command decoder, alongside the single-pixel command handlers.
//  - Byte stream: row, start column (little-endian, COL_BYTES), count (little-endian, COUNT_BYTES,

---
 rtl/control_cmd_writepixelrun_if.sv | 22 ++
 rtl/control_cmd_writepixelrun.sv | 150 +++++++++++++++
 tb/tb_control_cmd_writepixelrun.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/control_cmd_writepixelrun_if.sv
// control_cmd_writepixelrun_if: payload byte stream in, framebuffer byte-write port out.
//   ADDR_W            width of the {row,col,pixel} framebuffer address
//   enable, data_in   payload byte stream from the command decoder
//   addr, data_out    framebuffer byte write target and data
//   ram_write_enable  high while pixel bytes are streamed
//   ram_access_start  toggles once per in-range pixel byte
//   done, busy        command completion pulse / command in progress
//   modport master    command decoder side; modport slave: the parser
interface control_cmd_writepixelrun_if #(parameter int ADDR_W = 12);
    logic              enable;
    logic [7:0]        data_in;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_out;
    logic              ram_write_enable;
    logic              ram_access_start;
    logic              done;
    logic              busy;
    modport master (output enable, data_in,
                    input  addr, data_out, ram_write_enable, ram_access_start, done, busy);
    modport slave  (input  enable, data_in,
                    output addr, data_out, ram_write_enable, ram_access_start, done, busy);
endinterface

// File: rtl/control_cmd_writepixelrun.sv
// control_cmd_writepixelrun: parses a write-pixel-run payload (row, LE start column,
// LE count N-1, then N pixels big-endian) into framebuffer byte writes with an
// auto-incrementing column.
//   clk    system clock
//   reset  synchronous reset, active-low
//   bus    control_cmd_writepixelrun_if.slave (enable/data_in in; addr, data_out,
//          ram_write_enable, ram_access_start, done, busy out)
// Optional feature: define CMD_WRITEPIXELRUN_ROWWRAP_EN to wrap a run past the last
// column onto column 0 of the next row (last row wraps to row 0). Without it, pixels
// past the end of the row are consumed without a write.
module control_cmd_writepixelrun #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int NUM_COLUMNS     = 64,
    parameter int NUM_ROWS        = 32,
    parameter int COL_BYTES       = (((NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1) + 7) / 8,
    parameter int COUNT_BYTES     = 1
) (
    input logic                        clk,
    input logic                        reset,
    control_cmd_writepixelrun_if.slave bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
    localparam int PIX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
    localparam int ADDR_W = ROW_W + COL_W + PIX_W;
    // Column register holds the whole start-column field plus one spare bit, so the
    // largest start column plus the longest run can never wrap back into range.
    localparam int CW = 8 * ((COL_BYTES > COUNT_BYTES) ? COL_BYTES : COUNT_BYTES) + 1;
    localparam int RW = 8 * COUNT_BYTES;

    typedef enum logic [2:0] {ST_ROW, ST_COL, ST_COUNT, ST_PIXELS, ST_DONE} state_t;

    state_t              state, state_n;
    logic [ROW_W-1:0]    row_r, row_n;
    logic [CW-1:0]       col_r, col_n;
    logic [RW-1:0]       rem_r, rem_n;
    logic [PIX_W-1:0]    pix_r, pix_n;
    logic [3:0]          bidx, bidx_n;
    logic [ADDR_W-1:0]   addr_r, addr_n;
    logic [7:0]          dout_r, dout_n;
    logic                we_r, we_n, tog_r, tog_n, busy_r, busy_n, done_r, done_n;

    always_comb begin
        state_n = state;
        row_n   = row_r;
        col_n   = col_r;
        rem_n   = rem_r;
        pix_n   = pix_r;
        bidx_n  = bidx;
        addr_n  = addr_r;
        dout_n  = dout_r;
        we_n    = we_r;
        tog_n   = tog_r;
        busy_n  = busy_r;
        case (state)
            ST_ROW: if (bus.enable) begin
                row_n   = ROW_W'(bus.data_in);
                col_n   = '0;
                bidx_n  = '0;
                busy_n  = 1'b1;
                state_n = ST_COL;
            end
            ST_COL: if (bus.enable) begin
                col_n[8*int'(bidx) +: 8] = bus.data_in;
                bidx_n = bidx + 4'd1;
                if (int'(bidx) == COL_BYTES - 1) begin
                    bidx_n  = '0;
                    state_n = ST_COUNT;
                end
            end
            ST_COUNT: if (bus.enable) begin
                rem_n[8*int'(bidx) +: 8] = bus.data_in;
                bidx_n = bidx + 4'd1;
                if (int'(bidx) == COUNT_BYTES - 1) begin
                    bidx_n  = '0;
                    pix_n   = PIX_W'(BYTES_PER_PIXEL - 1);
                    we_n    = 1'b1;
                    state_n = ST_PIXELS;
                end
            end
            ST_PIXELS: if (bus.enable) begin
                dout_n = bus.data_in;
                addr_n = {row_r, col_r[COL_W-1:0], pix_r};
                tog_n  = (col_r < CW'(NUM_COLUMNS)) ? ~tog_r : tog_r;
                if (pix_r == '0) begin
                    pix_n = PIX_W'(BYTES_PER_PIXEL - 1);
                    col_n = col_r + 1'b1;
`ifdef CMD_WRITEPIXELRUN_ROWWRAP_EN
                    if (col_r + 1'b1 == CW'(NUM_COLUMNS)) begin
                        col_n = '0;
                        row_n = (row_r == ROW_W'(NUM_ROWS - 1)) ? '0 : row_r + 1'b1;
                    end
`endif
                    if (rem_r == '0)
                        state_n = ST_DONE;
                    else
                        rem_n = rem_r - 1'b1;
                end else begin
                    pix_n = pix_r - 1'b1;
                end
            end
            ST_DONE: begin
                we_n    = 1'b0;
                busy_n  = 1'b0;
                dout_n  = '0;
                addr_n  = '0;
                state_n = ST_ROW;
            end
            default: state_n = ST_ROW;
        endcase
        done_n = (state_n == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_ROW;
            row_r  <= '0;
            col_r  <= '0;
            rem_r  <= '0;
            pix_r  <= '0;
            bidx   <= '0;
            addr_r <= '0;
            dout_r <= '0;
            we_r   <= 1'b0;
            tog_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            row_r  <= row_n;
            col_r  <= col_n;
            rem_r  <= rem_n;
            pix_r  <= pix_n;
            bidx   <= bidx_n;
            addr_r <= addr_n;
            dout_r <= dout_n;
            we_r   <= we_n;
            tog_r  <= tog_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    assign bus.addr             = addr_r;
    assign bus.data_out         = dout_r;
    assign bus.ram_write_enable = we_r;
    assign bus.ram_access_start = tog_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
endmodule

// File: tb/tb_control_cmd_writepixelrun.sv
// tb_control_cmd_writepixelrun: directed table plus randomized commands against a
// pixel-list reference model; output-hold and reset checks run alongside.
module tb_control_cmd_writepixelrun;
    localparam int BPP = 2, NC = 64, NR = 32, AW = 12;
`ifdef CMD_WRITEPIXELRUN_ROWWRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif
    localparam int ROWEND_TOG = WRAP ? 4 : 2;
    localparam int MAXRUN_TOG = WRAP ? 512 : 128;

    typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} wr_t;
    typedef struct {logic [7:0] row, col, cnt; bit gap; int tog; string nm;} vec_t;

    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;

    control_cmd_writepixelrun_if #(.ADDR_W(AW)) bus ();
    control_cmd_writepixelrun dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0, fails = 0, dones = 0;
    wr_t got[$];
    logic en_e = 1'b0, rst_e = 1'b0, mon_on = 1'b0;
    logic [AW+11:0] prev;
    vec_t tbl[8];

    task automatic chk(input string n, input logic [63:0] g, input logic [63:0] e);
        tests++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, g, e);
        end
    endtask

    function automatic logic [AW+11:0] snap();
        return {bus.addr, bus.data_out, bus.ram_write_enable, bus.ram_access_start, bus.busy, bus.done};
    endfunction

    always @(posedge clk) begin
        en_e  <= bus.enable;
        rst_e <= reset;
    end

    // prev bits: [0]=done [1]=busy [2]=ram_access_start [3]=ram_write_enable
    always @(negedge clk) if (mon_on) begin
        if (rst_e && bus.ram_access_start != prev[2]) got.push_back({bus.addr, bus.data_out});
        if (bus.done) dones++;
        if (!en_e && rst_e && !prev[0]) chk("hold", snap(), prev);
        prev = snap();
    end

    task automatic run_cmd(input string nm, input logic [7:0] row, input logic [7:0] col,
                           input logic [7:0] cnt, input bit gap, input int tog);
        logic [7:0] b[$];
        wr_t ex[$];
        int r, c;
        b.push_back(row);
        b.push_back(col);
        b.push_back(cnt);
        for (int k = 0; k < (int'(cnt) + 1) * BPP; k++) b.push_back(8'($urandom));
        r = int'(row) % NR;
        c = int'(col);
        for (int p = 0; p <= int'(cnt); p++) begin
            for (int j = 0; j < BPP; j++)
                if (c < NC) ex.push_back({AW'(r * NC * BPP + c * BPP + (BPP - 1 - j)), b[3 + p * BPP + j]});
            c++;
            if (WRAP && c == NC) begin
                c = 0;
                r = (r + 1) % NR;
            end
        end
        got.delete();
        dones = 0;
        foreach (b[k]) begin
            @(posedge clk); #1 bus.enable = 1'b1; bus.data_in = b[k];
            if (gap) begin
                @(posedge clk); #1 bus.enable = 1'b0; bus.data_in = 8'($urandom);
            end
        end
        @(posedge clk); #1 bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        chk({nm, " done"}, 64'(dones), 64'd1);
        chk({nm, " idle"}, {bus.busy, bus.ram_write_enable, bus.addr, bus.data_out}, '0);
        if (tog >= 0) chk({nm, " toggles"}, 64'(got.size()), 64'(tog));
        chk({nm, " writes"}, 64'(got.size()), 64'(ex.size()));
        for (int i = 0; i < got.size() && i < ex.size(); i++) chk({nm, " wr"}, got[i], ex[i]);
    endtask

    initial begin
        logic [7:0] rb[$];
        tbl[0] = '{8'h05, 8'h0A, 8'h00, 1'b0, 2, "single"};
        tbl[1] = '{8'h02, 8'h3C, 8'h02, 1'b0, 6, "run3"};
        tbl[2] = '{8'h02, 8'h3C, 8'h02, 1'b1, 6, "run3_gaps"};
        tbl[3] = '{8'h04, 8'h3F, 8'h01, 1'b0, ROWEND_TOG, "row_end"};
        tbl[4] = '{8'h1F, 8'h3F, 8'h01, 1'b0, ROWEND_TOG, "last_row_end"};
        tbl[5] = '{8'h07, 8'hC8, 8'h02, 1'b0, 0, "col_oob"};
        tbl[6] = '{8'hE5, 8'h03, 8'h00, 1'b1, 2, "row_trunc"};
        tbl[7] = '{8'h09, 8'h00, 8'hFF, 1'b0, MAXRUN_TOG, "max_run"};
        bus.enable = 1'b0;
        bus.data_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state", snap(), '0);
        @(posedge clk); #1 reset = 1'b1;
        prev = snap();
        mon_on = 1'b1;
        foreach (tbl[i]) run_cmd(tbl[i].nm, tbl[i].row, tbl[i].col, tbl[i].cnt, tbl[i].gap, tbl[i].tog);
        for (int i = 0; i < 25; i++)
            run_cmd("rand", 8'($urandom),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(56, 255)) : 8'($urandom_range(0, 63)),
                    8'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), -1);
        // Reset three bytes into a pixel run, then a fresh command must parse cleanly.
        rb = '{8'h03, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33};
        foreach (rb[k]) begin
            @(posedge clk); #1 bus.enable = 1'b1; bus.data_in = rb[k];
        end
        @(posedge clk); #1 bus.enable = 1'b0; reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("reset mid-run", snap(), '0);
        got.delete();
        dones = 0;
        rb = '{8'h05, 8'h0A, 8'h00, 8'hAB, 8'hCD};
        foreach (rb[k]) begin
            @(posedge clk); #1 bus.enable = 1'b1; bus.data_in = rb[k];
        end
        @(posedge clk); #1 bus.enable = 1'b0;
        repeat (4) @(negedge clk);
        chk("post-reset done", 64'(dones), 64'd1);
        chk("post-reset writes", 64'(got.size()), 64'd2);
        if (got.size() == 2) begin
            chk("post-reset wr0", got[0], {AW'(5 * 128 + 10 * 2 + 1), 8'hAB});
            chk("post-reset wr1", got[1], {AW'(5 * 128 + 10 * 2 + 0), 8'hCD});
        end
        chk("post-reset busy", 64'(bus.busy), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
